// File: rtl/stp_pkg.sv
// Shared definitions for the serial-to-parallel frame buffer: FSM encoding,
// default geometry and the count-width helper.
package stp_pkg;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_PENDING = 1'b1
  } stp_state_e;

  localparam int STP_DW_DEF    = 16;
  localparam int STP_DEPTH_DEF = 16;

  // Width needed to hold a count in the range 0..depth inclusive.
  function automatic int clog2p1(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stp_collect_bank.sv
// DEPTH x DW collect register file with write pointer. It presents the frame in
// progress as a zero-padded flat bus, optionally including the word being written.
module stp_collect_bank
  import stp_pkg::*;
#(
  parameter int DW    = STP_DW_DEF,
  parameter int DEPTH = STP_DEPTH_DEF,
  parameter int CW    = clog2p1(STP_DEPTH_DEF)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [DW-1:0]       wr_data,
  input  logic                hold,
  input  logic                clr,
  output logic [CW-1:0]       wr_ptr,
  output logic [CW-1:0]       word_cnt,
  output logic [DEPTH*DW-1:0] frame_data
);

  logic [DW-1:0] words_q [DEPTH];
  logic [DW-1:0] words_d [DEPTH];
  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic          full_q, full_d;
  logic          tail_incl;

  // A held frame keeps the pointer on its final slot; full_q marks that slot as occupied.
  always_comb begin
    words_d  = words_q;
    wr_ptr_d = wr_ptr_q;
    full_d   = full_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (wr_en && (wr_ptr_q == CW'(k))) words_d[k] = wr_data;
    end
    if (clr) begin
      wr_ptr_d = '0;
      full_d   = 1'b0;
    end else if (wr_en && hold) begin
      full_d   = 1'b1;
    end else if (wr_en) begin
      wr_ptr_d = wr_ptr_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) words_q[k] <= '0;
      wr_ptr_q <= '0;
      full_q   <= 1'b0;
    end else begin
      words_q  <= words_d;
      wr_ptr_q <= wr_ptr_d;
      full_q   <= full_d;
    end
  end

  assign tail_incl = full_q || wr_en;
  assign wr_ptr    = wr_ptr_q;
  assign word_cnt  = wr_ptr_q + CW'(tail_incl);

  // Slots beyond the frame read as zero so stale words never reach the output.
  always_comb begin
    frame_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < wr_ptr_q) begin
        frame_data[k*DW +: DW] = words_q[k];
      end else if (CW'(k) == wr_ptr_q) begin
        if (full_q)     frame_data[k*DW +: DW] = words_q[k];
        else if (wr_en) frame_data[k*DW +: DW] = wr_data;
      end
    end
  end

endmodule

// File: rtl/stp_frame_buf.sv
// Double-buffered serial-to-parallel frame buffer: collects DW-bit words into frames
// of up to DEPTH words and hands each frame over a valid/ready flat parallel bus.
module stp_frame_buf
  import stp_pkg::*;
#(
  parameter int DW    = STP_DW_DEF,
  parameter int DEPTH = STP_DEPTH_DEF,
  parameter int CW    = clog2p1(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [DW-1:0]       in_data,
  input  logic                in_last,
  output logic                in_ready,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DEPTH*DW-1:0] out_data,
  output logic [CW-1:0]       out_count
);

  stp_state_e          state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic [DEPTH*DW-1:0] out_data_q, out_data_d;
  logic [CW-1:0]       out_count_q, out_count_d;

  logic                in_ready_c;
  logic                accept;
  logic                last_acc;
  logic                out_free;
  logic                transfer;
  logic                bank_hold;
  logic                bank_clr;
  logic [CW-1:0]       wr_ptr;
  logic [CW-1:0]       word_cnt;
  logic [DEPTH*DW-1:0] frame_data;

  stp_collect_bank #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_bank (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (accept),
    .wr_data    (in_data),
    .hold       (bank_hold),
    .clr        (bank_clr),
    .wr_ptr     (wr_ptr),
    .word_cnt   (word_cnt),
    .frame_data (frame_data)
  );

  // Flush gates in_ready so a word presented alongside it is never taken.
  always_comb begin
    in_ready_c = (state_q == ST_COLLECT) && !flush;
    accept     = in_valid && in_ready_c;
    last_acc   = accept && (in_last || (wr_ptr == CW'(DEPTH - 1)));
    out_free   = !out_valid_q || out_ready;
    transfer   = 1'b0;
    state_d    = state_q;
    case (state_q)
      ST_COLLECT: begin
        if (last_acc) begin
          if (out_free) transfer = 1'b1;
          else          state_d  = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (flush) begin
          state_d = ST_COLLECT;
        end else if (out_free) begin
          transfer = 1'b1;
          state_d  = ST_COLLECT;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
    bank_hold = last_acc && !out_free;
    bank_clr  = transfer || flush;
  end

  // A transfer on the same edge as a consumer take keeps out_valid high with new data.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    if (transfer) begin
      out_valid_d = 1'b1;
      out_data_d  = frame_data;
      out_count_d = word_cnt;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_COLLECT;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

endmodule

// File: doc/stp_frame_buf.md
Name: stp_frame_buf

Overview:
Parametrised serial-to-parallel frame buffer. It is the successor to the fixed 16x16 FIR-output deserialiser.
- Collects DW-bit words from the FIR stream into frames of up to DEPTH words.
- Presents each frame as one flat parallel bus with a valid/ready handshake.
- Double-buffered: the next frame collects while the previous one is held for the consumer.
- Supports short frames (in_last), zero-padding and a synchronous flush.

Parameters:
DW, 16, word width in bits (>=1)
DEPTH, 16, words per full frame (>=2, need not be a power of two)
CW, $clog2(DEPTH+1), width of the word-count fields (derived; do not override)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  input word valid
in_data  input  DW  input word (fir_d successor)
in_last  input  1  final word of a short frame; qualified by in_valid
in_ready  output  1  block can accept a word this cycle
flush  input  1  synchronous discard of the partially collected frame
out_valid  output  1  out_data/out_count hold a complete frame
out_ready  input  1  consumer takes the frame this cycle
out_data  output  DEPTH*DW  word k at [k*DW +: DW]; word 0 is the first received
out_count  output  CW  number of real words in the frame (1..DEPTH)

Behaviour:
- Reset (rst=0, asynchronous): collect bank, out_data, out_count, wr_ptr and out_valid are all 0; state=COLLECT. in_ready=1 while in reset and after release.
- Accept condition: in_valid && in_ready. Defined as in_ready = (state==COLLECT) && !flush.
- States:
  - COLLECT: each accept writes in_data to collect[wr_ptr] and increments wr_ptr.
  - The frame completes on an accept with wr_ptr==DEPTH-1, or on an accept with in_last=1.
  - out_free = !out_valid || out_ready.
  - If the frame completes and out_free: transfer in the same edge. The final word goes straight into its slot and COLLECT continues with wr_ptr=0.
  - If the frame completes and !out_free: go to PENDING and hold the collect bank.
  - PENDING: in_ready=0. When out_free: transfer, wr_ptr=0, return to COLLECT.
- Transfer edge:
  - out_data slot k <- word k for k < n, where n is the word count.
  - Slots k >= n <- 0 (zero-pad; stale data never leaks).
  - out_count <- n; out_valid <- 1.
- Latency: out_valid rises on the clock edge that accepts the final word of the frame (visible the following cycle).
- out_valid clears on an edge where out_ready=1, unless a transfer occurs on the same edge. In that case out_valid stays 1 with new data (back-to-back frames, no bubble).
- out_ready while out_valid=0 is ignored.
- out_data and out_count are stable while out_valid && !out_ready.
- in_last on the DEPTH-th word: treated as a normal full frame, n=DEPTH.
- in_last on the first word: n=1.
- in_last while in_valid=0: ignored.
- flush:
  - In COLLECT: wr_ptr <- 0 and the partial words are discarded. in_ready=0 that cycle, so flush wins over a simultaneous in_valid.
  - In PENDING: discards the held frame and returns to COLLECT.
  - The output bank and out_valid are never affected by flush.
- Reset mid-frame or mid-handshake: everything returns to reset values immediately. No partial frame survives.
- wr_ptr range is 0..DEPTH-1. It never wraps without a transfer.

Decomposition:
- Shared package stp_pkg holds:
  - the state encoding (ST_COLLECT, ST_PENDING);
  - default DW/DEPTH constants;
  - a count-width function clog2p1(DEPTH).
- One natural sub-module: stp_collect_bank (DEPTH x DW register file with write pointer, word-count output and zero-pad read mask).
- FSM and output bank stay in the top level.

Test Plan:
- Full frame, DEPTH=16, DW=16: in_valid continuous with words 0x0001..0x0010, out_ready=1 -> out_valid one cycle after the 16th accept; out_data word0=0x0001, word15=0x0010; out_count=16; in_ready never drops.
- Short frame: 5 words 0xA000..0xA004 with in_last on the 5th -> out_count=5; words 0..4 match; words 5..15=0. A following full frame -> slots 5..15 now contain that frame's data.
- Back-pressure: out_ready=0; send 2 full frames -> frame 1 held stable on out_data; after the 2nd frame's 16th accept, in_ready=0 (PENDING); raise out_ready for one cycle -> frame 2 appears on the next edge; out_valid stays 1; in_ready returns to 1.
- Flush: 7 words in, then flush together with in_valid=1 and data 0xDEAD -> 0xDEAD not accepted; the next 16 words form a frame with out_count=16 that does not contain the discarded data.
- Async reset: assert rst=0 mid-frame (wr_ptr=9) while out_valid=1 -> out_valid=0 and out_data=0 without waiting for a clock edge; after release, the first 16 words form a clean frame.
- Parametric: DW=8, DEPTH=3, stream 0x11,0x22,0x33 repeated, out_ready=1 -> out_valid every 3 accepts; out_data=0x332211; out_count=3.
